imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 108 ++++++++++
 tb/tb_imem_responder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory fetch responder: one outstanding request, response WAIT_CYCLES+1 cycles after accept.
// Optional macro IMEM_FETCH_ERR_EN flags misaligned/out-of-range fetches with rsp_err and a NOP.
module imem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_instr,
    output logic                     rsp_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [1:0]  IDLE = 2'd0;
    localparam logic [1:0]  WAIT = 2'd1;
    localparam logic [1:0]  RESP = 2'd2;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_instr;
    logic        r_err;
    logic [31:0] r_mem [DEPTH];

    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_cap_addr;
    logic [31:0] w_cap_instr;
    logic        w_cap_err;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_instr = r_instr;
    assign rsp_err   = r_err;
    assign w_accept  = req_valid && req_ready;

    // Zero-wait fetches read straight off the request bus on the accept edge.
    assign w_cap_addr = (r_state == IDLE) ? req_addr : r_addr;
    assign w_capture  = (w_accept && (WAIT_CYCLES == 0)) || ((r_state == WAIT) && (r_cnt == 4'd0));

`ifdef IMEM_FETCH_ERR_EN
    always_comb begin
        w_cap_err   = (w_cap_addr[1:0] != 2'b00) || (w_cap_addr[31:AW+2] != '0);
        w_cap_instr = w_cap_err ? NOP : r_mem[w_cap_addr[AW+1:2]];
    end
`else
    logic w_unused;
    assign w_unused    = ^{w_cap_addr[31:AW+2], w_cap_addr[1:0], NOP};
    assign w_cap_err   = 1'b0;
    assign w_cap_instr = r_mem[w_cap_addr[AW+1:2]];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_instr <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_instr <= w_cap_instr;
                r_err   <= w_cap_err;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr <= req_addr;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Program memory is never reset; a capture on the same edge as a write sees the old word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (2 wait states and 0 wait states) against a transaction-level model.
module tb_imem_responder;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);
    localparam int W_A   = 2;
    localparam int W_B   = 0;

`ifdef IMEM_FETCH_ERR_EN
    localparam logic [31:0] EXP_BAD_INS = 32'h0000_0013;
    localparam logic        EXP_BAD_ERR = 1'b1;
`else
    localparam logic [31:0] EXP_BAD_INS = 32'hA500_0000;
    localparam logic        EXP_BAD_ERR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic [31:0]   req_addr;
    logic          rsp_ready;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;

    logic          a_rdy, a_vld, a_err;
    logic [31:0]   a_ins;
    logic          b_rdy, b_vld, b_err;
    logic [31:0]   b_ins;

    int checks   = 0;
    int failures = 0;

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(a_rdy), .req_addr(req_addr),
        .rsp_valid(a_vld), .rsp_ready(rsp_ready), .rsp_instr(a_ins), .rsp_err(a_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(b_rdy), .req_addr(req_addr),
        .rsp_valid(b_vld), .rsp_ready(rsp_ready), .rsp_instr(b_ins), .rsp_err(b_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding fetch per instance, response after wc further edges.
    bit          m_busy  [2];
    bit          m_val   [2];
    int          m_left  [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_instr [2];
    bit          m_err   [2];
    logic [31:0] m_mem   [DEPTH];

    function automatic void fetch(input logic [31:0] a, output logic [31:0] d, output bit e);
`ifdef IMEM_FETCH_ERR_EN
        if ((a % 4) != 0 || a >= 32'(4 * DEPTH)) begin
            d = 32'h0000_0013;
            e = 1'b1;
            return;
        end
`endif
        d = m_mem[(a / 4) % DEPTH];
        e = 1'b0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i]  = 1'b0;
                m_val[i]   = 1'b0;
                m_left[i]  = 0;
                m_instr[i] = 32'd0;
                m_err[i]   = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int wc;
                wc = (i == 0) ? W_A : W_B;
                if (m_val[i]) begin
                    if (rsp_ready) begin
                        m_val[i]  = 1'b0;
                        m_busy[i] = 1'b0;
                    end
                end else if (m_busy[i]) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        fetch(m_addr[i], m_instr[i], m_err[i]);
                        m_val[i] = 1'b1;
                    end
                end else if (req_valid) begin
                    m_busy[i] = 1'b1;
                    m_addr[i] = req_addr;
                    if (wc == 0) begin
                        fetch(m_addr[i], m_instr[i], m_err[i]);
                        m_val[i] = 1'b1;
                    end else begin
                        m_left[i] = wc;
                    end
                end
            end
            if (load_en) m_mem[load_addr] = load_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cmp_rdy_a", 32'(a_rdy), 32'(!m_busy[0]));
            chk("cmp_vld_a", 32'(a_vld), 32'(m_val[0]));
            chk("cmp_rdy_b", 32'(b_rdy), 32'(!m_busy[1]));
            chk("cmp_vld_b", 32'(b_vld), 32'(m_val[1]));
            if (m_val[0]) begin
                chk("cmp_ins_a", a_ins, m_instr[0]);
                chk("cmp_err_a", 32'(a_err), 32'(m_err[0]));
            end
            if (m_val[1]) begin
                chk("cmp_ins_b", b_ins, m_instr[1]);
                chk("cmp_err_b", 32'(b_err), 32'(m_err[1]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int n;
        n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        load_en   = 1'b0;
        while (!(a_rdy && b_rdy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_in_budget", 32'(n < 50), 32'd1);
    endtask

    initial begin
        int  lat_a, lat_b;
        bit  found;

        rst = 1'b0; req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_rdy_a", 32'(a_rdy), 32'd1);
        chk("rst_vld_a", 32'(a_vld), 32'd0);
        chk("rst_ins_a", a_ins, 32'd0);
        chk("rst_err_a", 32'(a_err), 32'd0);
        chk("rst_rdy_b", 32'(b_rdy), 32'd1);
        chk("rst_vld_b", 32'(b_vld), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = (i == 3) ? 32'hDEAD_BEEF : (32'hA500_0000 | 32'(i));
            @(negedge clk);
        end
        load_en = 1'b0;

        // Latency: k counts edges from the accept edge inclusive.
        req_valid = 1'b1; req_addr = 32'h0C; rsp_ready = 1'b1;
        lat_a = 0; lat_b = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (lat_a == 0 && a_vld) begin
                lat_a = k;
                chk("lat_ins_a", a_ins, 32'hDEAD_BEEF);
                chk("lat_err_a", 32'(a_err), 32'd0);
            end
            if (lat_b == 0 && b_vld) begin
                lat_b = k;
                chk("lat_ins_b", b_ins, 32'hDEAD_BEEF);
            end
            @(negedge clk);
            req_valid = 1'b0;
        end
        chk("latency_w2", 32'(lat_a), 32'd3);
        chk("latency_w0", 32'(lat_b), 32'd1);
        wait_idle();

        // Back-to-back zero-wait fetches; no accept on the response-handshake edge.
        req_valid = 1'b1; req_addr = 32'h00;
        @(posedge clk); #1;
        chk("b2b_vld0", 32'(b_vld), 32'd1);
        chk("b2b_rdy_in_resp", 32'(b_rdy), 32'd0);
        chk("b2b_ins0", b_ins, 32'hA500_0000);
        @(negedge clk);
        req_addr = 32'h04;
        @(posedge clk); #1;
        chk("b2b_idle_vld", 32'(b_vld), 32'd0);
        chk("b2b_idle_rdy", 32'(b_rdy), 32'd1);
        @(posedge clk); #1;
        chk("b2b_vld1", 32'(b_vld), 32'd1);
        chk("b2b_ins1", b_ins, 32'hA500_0001);
        @(negedge clk);
        wait_idle();

        // Held response under backpressure with ignored request pulses.
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h08;
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk); #1;
            found = a_vld;
        end
        chk("hold_rsp_seen", 32'(found), 32'd1);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            @(posedge clk); #1;
            chk("hold_vld_a", 32'(a_vld), 32'd1);
            chk("hold_ins_a", a_ins, 32'hA500_0002);
            chk("hold_rdy_a", 32'(a_rdy), 32'd0);
            chk("hold_ins_b", b_ins, 32'hA500_0002);
        end
        @(negedge clk);
        wait_idle();

        // Load and zero-wait capture of the same word on one edge.
        req_valid = 1'b1; req_addr = 32'h04; rsp_ready = 1'b0;
        load_en = 1'b1; load_addr = AW'(1); load_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("collide_vld_b", 32'(b_vld), 32'd1);
        chk("collide_old_b", b_ins, 32'hA500_0001);
        @(negedge clk);
        wait_idle();
        req_valid = 1'b1; req_addr = 32'h04;
        @(posedge clk); #1;
        chk("collide_new_b", b_ins, 32'hCAFE_F00D);
        @(negedge clk);
        wait_idle();

        // Asynchronous reset in the middle of the wait phase.
        req_valid = 1'b1; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_vld_a", 32'(a_vld), 32'd0);
        chk("arst_rdy_a", 32'(a_rdy), 32'd1);
        chk("arst_ins_a", a_ins, 32'd0);
        chk("arst_err_a", 32'(a_err), 32'd0);
        chk("arst_rdy_b", 32'(b_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("arst_no_rsp_a", 32'(a_vld), 32'd0);
        end
        @(negedge clk);

        // Out-of-range and misaligned fetches.
        req_valid = 1'b1; req_addr = 32'h400;
        @(posedge clk); #1;
        chk("oor_ins_b", b_ins, EXP_BAD_INS);
        chk("oor_err_b", 32'(b_err), 32'(EXP_BAD_ERR));
        @(negedge clk);
        wait_idle();
        req_valid = 1'b1; req_addr = 32'h02;
        @(posedge clk); #1;
        chk("mis_ins_b", b_ins, EXP_BAD_INS);
        chk("mis_err_b", 32'(b_err), 32'(EXP_BAD_ERR));
        @(negedge clk);
        wait_idle();

        // Randomized traffic with loads, backpressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                req_valid = 1'b0;
                load_en   = 1'b0;
                rst       = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end else begin
                req_valid = ($urandom_range(0, 2) != 0);
                req_addr  = ($urandom_range(0, 7) == 0) ? ($urandom & 32'h7FF)
                                                        : (32'($urandom_range(0, DEPTH - 1)) << 2);
                rsp_ready = ($urandom_range(0, 3) != 0);
                load_en   = ($urandom_range(0, 3) == 0);
                load_addr = AW'($urandom_range(0, DEPTH - 1));
                load_data = $urandom;
                @(negedge clk);
            end
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
